// File: rtl/hsid_x_obi_rr_arbiter.sv
// hsid_x_obi_rr_arbiter: round-robin OBI arbiter; clk/rst, req_i/rsp_o upstream, mem_req_o/mem_rsp_i downstream, outstanding_o, err_o
package hsid_x_obi_inf_pkg;
  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;
  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;
endpackage

module hsid_x_obi_rr_arbiter
  import hsid_x_obi_inf_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int MAX_OUTSTANDING = 4,
  localparam int IDX_W = $clog2(NUM_REQ),
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1,
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  obi_req_t         req_i [NUM_REQ],
  output obi_resp_t        rsp_o [NUM_REQ],
  output obi_req_t         mem_req_o,
  input  obi_resp_t        mem_rsp_i,
  output logic [CNT_W-1:0] outstanding_o,
  output logic             err_o
);
  typedef enum logic {IDLE, LOCKED} state_e;
  state_e state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d, rr_q, rr_d, sel, cand, head;
  logic [IDX_W-1:0] fifo_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic sel_vld, full, issue, hs, pop, err_q;
  function automatic logic [PTR_W-1:0] inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction
  // Scan downward so the candidate closest to the rr pointer is written last and wins.
  always_comb begin
    sel = rr_q;
    cand = '0;
    sel_vld = 1'b0;
    if (state_q == LOCKED) begin
      sel = owner_q;
      sel_vld = req_i[owner_q].req;
    end else begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        cand = IDX_W'((int'(rr_q) + i) % NUM_REQ);
        if (req_i[cand].req) begin
          sel = cand;
          sel_vld = 1'b1;
        end
      end
    end
  end
  assign full  = cnt_q == CNT_W'(MAX_OUTSTANDING);
  assign issue = sel_vld && !full;
  assign hs    = issue && mem_rsp_i.gnt;
  assign pop   = mem_rsp_i.rvalid && (cnt_q != '0);
  assign head  = fifo_q[rptr_q];
  always_comb begin
    mem_req_o = sel_vld ? req_i[sel] : '0;
    mem_req_o.req = issue;
  end
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      rsp_o[k].gnt    = hs && (sel == IDX_W'(k));
      rsp_o[k].rvalid = pop && (head == IDX_W'(k));
      rsp_o[k].rdata  = mem_rsp_i.rdata;
    end
  end
  // A full FIFO freezes arbitration; an owner dropping req releases the lock.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d = rr_q;
    if (issue) begin
      state_d = hs ? IDLE : LOCKED;
      owner_d = sel;
      if (hs) rr_d = (sel == IDX_W'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
    end else if (!sel_vld) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q <= rr_d;
      if (hs) wptr_q <= inc(wptr_q);
      if (pop) rptr_q <= inc(rptr_q);
      cnt_q <= cnt_q + CNT_W'(hs) - CNT_W'(pop);
      if (mem_rsp_i.rvalid && cnt_q == '0) err_q <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (hs) fifo_q[wptr_q] <= sel;
  end
  assign outstanding_o = cnt_q;
  assign err_o = err_q;
endmodule

// File: tb/tb_hsid_x_obi_rr_arbiter.sv
// tb_hsid_x_obi_rr_arbiter: randomized self-checking bench with a transaction-level arbiter model
module tb_hsid_x_obi_rr_arbiter;
  import hsid_x_obi_inf_pkg::*;
  localparam int N = 2;
  localparam int MO = 4;
  logic clk = 1'b0;
  logic rst;
  obi_req_t req_i [N];
  obi_resp_t rsp_o [N];
  obi_req_t mem_req_o;
  obi_resp_t mem_rsp_i;
  logic [2:0] outstanding_o;
  logic err_o;
  hsid_x_obi_rr_arbiter #(.NUM_REQ(N), .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .rsp_o(rsp_o),
    .mem_req_o(mem_req_o), .mem_rsp_i(mem_rsp_i),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  int m_rr, m_owner;
  bit m_lock, m_err;
  int m_q [$];
  logic [31:0] exp_rd [N][$];
  logic [31:0] mem_pend [$];
  int g_log [$];
  int gnt_pct, rv_pct;
  bit auto_m, inject;
  bit act [N];
  bit granted [N];
  bit obs_gnt [N];
  bit obs_rv [N];
  bit obs_mreq;
  logic [31:0] obs_addr, obs_rdata;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return {a[15:0] & 16'h3FFF, a[31:16] & 16'h3FFF};
  endfunction
  task automatic model_reset();
    m_q.delete();
    m_rr = 0;
    m_lock = 0;
    m_owner = 0;
    m_err = 0;
    for (int k = 0; k < N; k++) begin
      exp_rd[k].delete();
      granted[k] = 0;
    end
  endtask
  task automatic set_req(input int k, input bit r, input logic [31:0] a);
    req_i[k] = '0;
    req_i[k].req = r;
    req_i[k].be = 4'hF;
    req_i[k].addr = a;
  endtask
  task automatic cycle();
    int sel, h;
    bit vld, full, issue, hs, pop, empty_rv;
    if (auto_m) begin
      for (int k = 0; k < N; k++) begin
        if (granted[k] || !act[k]) begin
          act[k] = 1'($urandom_range(0, 1));
          req_i[k].addr = $urandom;
          req_i[k].wdata = $urandom;
          req_i[k].we = 1'($urandom_range(0, 1));
          req_i[k].be = 4'($urandom);
        end else if ($urandom_range(0, 99) < 2) begin
          act[k] = 0;
        end
        req_i[k].req = act[k];
      end
    end
    for (int k = 0; k < N; k++) granted[k] = 0;
    mem_rsp_i.gnt = $urandom_range(0, 99) < gnt_pct;
    mem_rsp_i.rvalid = 1'b0;
    mem_rsp_i.rdata = $urandom;
    if (mem_pend.size() > 0 && $urandom_range(0, 99) < rv_pct) begin
      mem_rsp_i.rvalid = 1'b1;
      mem_rsp_i.rdata = mem_pend.pop_front();
    end else if (inject) begin
      mem_rsp_i.rvalid = 1'b1;
    end
    #4;
    full = m_q.size() >= MO;
    vld = 0;
    sel = m_rr;
    if (m_lock) begin
      sel = m_owner;
      vld = req_i[sel].req;
    end else begin
      for (int i = 0; i < N; i++)
        if (!vld && req_i[(m_rr + i) % N].req) begin
          sel = (m_rr + i) % N;
          vld = 1;
        end
    end
    issue = vld && !full;
    hs = issue && mem_rsp_i.gnt;
    pop = mem_rsp_i.rvalid && m_q.size() > 0;
    empty_rv = mem_rsp_i.rvalid && m_q.size() == 0;
    h = pop ? m_q[0] : -1;
    check("mem_req", 32'(mem_req_o.req), 32'(issue));
    check("mem_addr", mem_req_o.addr, vld ? req_i[sel].addr : 32'h0);
    check("mem_wdata", mem_req_o.wdata, vld ? req_i[sel].wdata : 32'h0);
    for (int k = 0; k < N; k++) begin
      check($sformatf("gnt%0d", k), 32'(rsp_o[k].gnt), 32'(hs && sel == k));
      check($sformatf("rvalid%0d", k), 32'(rsp_o[k].rvalid), 32'(h == k));
      check($sformatf("rdata_bc%0d", k), rsp_o[k].rdata, mem_rsp_i.rdata);
      obs_gnt[k] = rsp_o[k].gnt;
      obs_rv[k] = rsp_o[k].rvalid;
    end
    if (pop) check("rdata_route", rsp_o[h].rdata, exp_rd[h].pop_front());
    check("outstanding", 32'(outstanding_o), 32'(m_q.size()));
    check("err", 32'(err_o), 32'(m_err));
    obs_mreq = mem_req_o.req;
    obs_addr = mem_req_o.addr;
    obs_rdata = rsp_o[0].rdata;
    @(posedge clk);
    if (obs_mreq && mem_rsp_i.gnt) mem_pend.push_back(rd_of(obs_addr));
    for (int k = 0; k < N; k++) if (obs_gnt[k]) g_log.push_back(k);
    if (hs) begin
      m_q.push_back(sel);
      exp_rd[sel].push_back(rd_of(req_i[sel].addr));
      granted[sel] = 1;
    end
    if (pop) void'(m_q.pop_front());
    if (empty_rv) m_err = 1;
    if (issue) begin
      m_lock = !hs;
      m_owner = sel;
      if (hs) m_rr = (sel + 1) % N;
    end else if (!vld) begin
      m_lock = 0;
    end
    @(negedge clk);
  endtask
  task automatic reset_pulse(input bit clear_mem);
    rst = 1'b1;
    #1;
    model_reset();
    if (clear_mem) mem_pend.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic drain();
    for (int k = 0; k < N; k++) req_i[k].req = 1'b0;
    auto_m = 0;
    rv_pct = 100;
    for (int i = 0; i < 40 && (m_q.size() > 0 || mem_pend.size() > 0); i++) cycle();
  endtask
  initial begin
    int n;
    rst = 1'b1;
    for (int k = 0; k < N; k++) begin
      set_req(k, 0, 32'h0);
      act[k] = 0;
    end
    mem_rsp_i = '0;
    auto_m = 0;
    inject = 0;
    gnt_pct = 100;
    rv_pct = 100;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_outstanding", 32'(outstanding_o), 32'h0);
    check("rst_err", 32'(err_o), 32'h0);
    check("rst_mem_req", 32'(mem_req_o.req), 32'h0);
    check("rst_mem_addr", mem_req_o.addr, 32'h0);
    rst = 1'b0;
    set_req(0, 1, 32'h0000_0010);
    cycle();
    check("t1_gnt0", 32'(obs_gnt[0]), 32'h1);
    check("t1_gnt1", 32'(obs_gnt[1]), 32'h0);
    set_req(0, 0, 32'h0000_0010);
    cycle();
    check("t1_rv0", 32'(obs_rv[0]), 32'h1);
    check("t1_rv1", 32'(obs_rv[1]), 32'h0);
    check("t1_rdata", obs_rdata, 32'h0010_0000);
    drain();
    reset_pulse(1);
    g_log.delete();
    set_req(0, 1, 32'h10);
    set_req(1, 1, 32'h20);
    repeat (8) cycle();
    for (int i = 0; i < 4; i++) check($sformatf("t2_order%0d", i), 32'(g_log[i]), 32'(i % 2));
    drain();
    reset_pulse(1);
    gnt_pct = 0;
    set_req(0, 0, 32'h10);
    set_req(1, 1, 32'h0001_0004);
    cycle();
    req_i[0].req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t3_addr_hold", obs_addr, 32'h0001_0004);
    end
    gnt_pct = 100;
    cycle();
    check("t3_gnt1", 32'(obs_gnt[1]), 32'h1);
    req_i[1].req = 1'b0;
    cycle();
    check("t3_gnt0", 32'(obs_gnt[0]), 32'h1);
    check("t3_rv1", 32'(obs_rv[1]), 32'h1);
    check("t3_rdata", obs_rdata, 32'h0004_0001);
    drain();
    reset_pulse(1);
    auto_m = 1;
    for (int b = 0; b < 15; b++) begin
      gnt_pct = $urandom_range(10, 100);
      rv_pct = $urandom_range(10, 100);
      repeat (100) cycle();
    end
    drain();
    reset_pulse(1);
    g_log.delete();
    gnt_pct = 100;
    rv_pct = 0;
    set_req(0, 1, 32'h0000_0100);
    set_req(1, 1, 32'h0000_0200);
    repeat (6) cycle();
    check("t4_grants", 32'(g_log.size()), 32'h4);
    check("t4_req_low", 32'(obs_mreq), 32'h0);
    check("t4_outstanding", 32'(outstanding_o), 32'h4);
    n = g_log.size();
    rv_pct = 100;
    cycle();
    rv_pct = 0;
    check("t4_no_bypass", 32'(g_log.size()), 32'(n));
    cycle();
    check("t4_regrant", 32'(g_log.size()), 32'(n + 1));
    drain();
    reset_pulse(1);
    inject = 1;
    cycle();
    inject = 0;
    check("t5_no_rv0", 32'(obs_rv[0]), 32'h0);
    check("t5_no_rv1", 32'(obs_rv[1]), 32'h0);
    repeat (5) cycle();
    check("t5_err_sticky", 32'(err_o), 32'h1);
    reset_pulse(1);
    check("t5_err_clr", 32'(err_o), 32'h0);
    rv_pct = 0;
    set_req(0, 1, 32'h0000_0300);
    set_req(1, 1, 32'h0000_0400);
    repeat (2) cycle();
    check("t6_inflight", 32'(outstanding_o), 32'h2);
    #2;
    rst = 1'b1;
    #1;
    check("t6_outstanding", 32'(outstanding_o), 32'h0);
    check("t6_err", 32'(err_o), 32'h0);
    check("t6_rv0", 32'(rsp_o[0].rvalid), 32'h0);
    check("t6_rv1", 32'(rsp_o[1].rvalid), 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drain();
    check("t6_late_err", 32'(err_o), 32'h1);
    g_log.delete();
    gnt_pct = 100;
    set_req(0, 1, 32'h0000_0500);
    set_req(1, 1, 32'h0000_0600);
    cycle();
    check("t6_rr_zero", 32'(g_log.size() > 0 ? g_log[0] : -1), 32'h0);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
